reg_scoreboard: RTL and testbench



---
 rtl/reg_scoreboard.sv | 99 +++++++++
 tb/tb_reg_scoreboard.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register-state scoreboard beside the ID stage: tracks in-flight destination writes,
// raises load-use stalls and tells ID whether the register-file read values are current.
module reg_scoreboard #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned LOAD_LAT       = 1,
    parameter int unsigned ALU_LAT        = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      id_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
    input  logic                      id_reg_write_i,
    input  logic                      id_mem_read_i,
    input  logic                      flush_i,
    input  logic                      wb_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
    output logic                      pc_keep_o,
    output logic                      if_id_keep_o,
    output logic                      id_ex_zero_o,
    output logic                      trust_o,
    output logic [NUM_REGS-1:0]       busy_vec_o,
    output logic                      err_o
);

    logic [1:0]          inflight  [NUM_REGS];
    logic [1:0]          ready_cnt [NUM_REGS];
    logic                err_q;
    logic [NUM_REGS-1:0] busy_vec;
    logic [NUM_REGS-1:0] iss_vec;
    logic [NUM_REGS-1:0] wb_vec;
    logic                rs1_busy, rs2_busy;
    logic                rs1_wait, rs2_wait;
    logic                stall, issue, wb;
    logic                wb_orphan, iss_over;
    logic [1:0]          new_lat;

    always_comb begin
        busy_vec = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            busy_vec[r] = (inflight[r] != 2'd0);
        end
    end

    always_comb begin
        rs1_busy  = (id_rs1_i != '0) && busy_vec[id_rs1_i];
        rs2_busy  = (id_rs2_i != '0) && busy_vec[id_rs2_i];
        rs1_wait  = rs1_busy && (ready_cnt[id_rs1_i] != 2'd0);
        rs2_wait  = rs2_busy && (ready_cnt[id_rs2_i] != 2'd0);
        stall     = id_valid_i && (rs1_wait || rs2_wait);
        issue     = id_valid_i && id_reg_write_i && (id_rd_i != '0) && !stall && !flush_i;
        wb        = wb_valid_i && (wb_rd_i != '0);
        iss_vec   = issue ? (NUM_REGS'(1) << id_rd_i) : '0;
        wb_vec    = wb ? (NUM_REGS'(1) << wb_rd_i) : '0;
        new_lat   = id_mem_read_i ? 2'(LOAD_LAT) : 2'(ALU_LAT);
        wb_orphan = wb && (inflight[wb_rd_i] == 2'd0);
        // A same-register writeback cancels the increment, so it cannot overflow.
        iss_over  = issue && (inflight[id_rd_i] == 2'd3) && !(wb && (wb_rd_i == id_rd_i));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                inflight[r]  <= '0;
                ready_cnt[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (iss_vec[r]) begin
                    ready_cnt[r] <= new_lat;
                    if (!wb_vec[r] && (inflight[r] != 2'd3)) begin
                        inflight[r] <= inflight[r] + 2'd1;
                    end
                end else begin
                    if (ready_cnt[r] != 2'd0) begin
                        ready_cnt[r] <= ready_cnt[r] - 2'd1;
                    end
                    if (wb_vec[r] && (inflight[r] != 2'd0)) begin
                        inflight[r] <= inflight[r] - 2'd1;
                    end
                end
            end
            if (wb_orphan || iss_over) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pc_keep_o    = stall;
    assign if_id_keep_o = stall;
    assign id_ex_zero_o = stall;
    assign trust_o      = !(rs1_busy || rs2_busy);
    assign busy_vec_o   = busy_vec;
    assign err_o        = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed pipeline scenarios then randomized traffic,
// checked against a time-stamped model of outstanding register writes.
module tb_reg_scoreboard;

    localparam int AW   = 5;
    localparam int NR   = 32;
    localparam int LLAT = 1;
    localparam int ALAT = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_reg_write, id_mem_read, flush, wb_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic          pc_keep, if_id_keep, id_ex_zero, trust, err;
    logic [NR-1:0] busy_vec;

    always #5 clk = ~clk;

    reg_scoreboard #(
        .REG_ADDR_WIDTH(AW),
        .NUM_REGS      (NR),
        .LOAD_LAT      (LLAT),
        .ALU_LAT       (ALAT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_valid_i    (id_valid),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_rd_i       (id_rd),
        .id_reg_write_i(id_reg_write),
        .id_mem_read_i (id_mem_read),
        .flush_i       (flush),
        .wb_valid_i    (wb_valid),
        .wb_rd_i       (wb_rd),
        .pc_keep_o     (pc_keep),
        .if_id_keep_o  (if_id_keep),
        .id_ex_zero_o  (id_ex_zero),
        .trust_o       (trust),
        .busy_vec_o    (busy_vec),
        .err_o         (err)
    );

    typedef struct {
        bit            stall;
        bit            trust;
        logic [NR-1:0] busy;
        bit            err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: outstanding write count per register, and the first cycle at which the
    // newest write's result can be forwarded.
    int cnt    [NR];
    int fwd_at [NR];
    bit m_err;
    int cyc;

    task automatic check(input string name, input logic [NR-1:0] act, input logic [NR-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc_keep",    NR'(pc_keep),    NR'(e.stall));
                check("if_id_keep", NR'(if_id_keep), NR'(e.stall));
                check("id_ex_zero", NR'(id_ex_zero), NR'(e.stall));
                check("trust",      NR'(trust),      NR'(e.trust));
                check("busy_vec",   busy_vec,        e.busy);
                check("err",        NR'(err),        NR'(e.err));
            end
        end
    end

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            cnt[r]    = 0;
            fwd_at[r] = 0;
        end
        m_err = 1'b0;
    endtask

    // Drives one cycle of inputs, queues the expected response, advances the model.
    task automatic step(input bit v, input int r1, input int r2, input int rd_, input bit rw,
                        input bit mr, input bit fl, input bit wv, input int wr, input bit rs);
        exp_t e;
        bit b1, b2, iss, w;
        id_valid     = v;
        id_rs1       = AW'(r1);
        id_rs2       = AW'(r2);
        id_rd        = AW'(rd_);
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
        wb_valid     = wv;
        wb_rd        = AW'(wr);
        rst          = rs;

        b1      = (r1 != 0) && (cnt[r1] != 0);
        b2      = (r2 != 0) && (cnt[r2] != 0);
        e.stall = v && ((b1 && cyc < fwd_at[r1]) || (b2 && cyc < fwd_at[r2]));
        e.trust = !(b1 || b2);
        e.busy  = '0;
        for (int r = 1; r < NR; r++) e.busy[r] = (cnt[r] != 0);
        e.err   = m_err;
        exp_q.push_back(e);

        if (rs) begin
            model_reset();
        end else begin
            iss = v && rw && (rd_ != 0) && !e.stall && !fl;
            w   = wv && (wr != 0);
            if (w && cnt[wr] == 0) m_err = 1'b1;
            if (iss && w && rd_ == wr) begin
                fwd_at[rd_] = cyc + 1 + (mr ? LLAT : ALAT);
            end else begin
                if (iss) begin
                    if (cnt[rd_] == 3) m_err = 1'b1;
                    else cnt[rd_]++;
                    fwd_at[rd_] = cyc + 1 + (mr ? LLAT : ALAT);
                end
                if (w && cnt[wr] > 0) cnt[wr]--;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int r1, input int r2);
        step(1, r1, r2, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wback(input int r);
        step(0, 0, 0, 0, 0, 0, 0, 1, r, 0);
    endtask

    initial begin
        int pend[$];
        int wr;
        bit v, rw, mr, fl, wv;

        cyc = 0;
        model_reset();
        rst = 1'b1;
        id_valid = 0; id_reg_write = 0; id_mem_read = 0; flush = 0; wb_valid = 0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; wb_rd = '0;
        repeat (2) @(posedge clk);
        #1;

        // Idle state after reset
        idle(5, 6);
        // Load-use: one bubble, then distrust until writeback
        step(1, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        step(1, 5, 0, 10, 1, 0, 0, 0, 0, 0);
        step(1, 5, 0, 10, 1, 0, 0, 0, 0, 0);
        idle(5, 10);
        wback(5);
        wback(10);
        idle(5, 10);
        // ALU result: no stall, distrusted until writeback
        step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        idle(7, 0);
        idle(0, 7);
        wback(7);
        idle(7, 7);
        // WAW on x9
        step(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        idle(9, 0);
        wback(9);
        wback(9);
        idle(9, 0);
        // Same-cycle issue and writeback on x4, then x0 destination
        step(1, 0, 0, 4, 1, 1, 0, 0, 0, 0);
        idle(4, 0);
        step(1, 0, 0, 4, 1, 1, 0, 1, 4, 0);
        idle(4, 0);
        idle(4, 0);
        wback(4);
        step(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        idle(4, 0);
        // Flushed load, then orphan writeback makes err sticky
        step(1, 0, 0, 3, 1, 1, 1, 0, 0, 0);
        idle(3, 0);
        wback(12);
        idle(12, 3);
        idle(0, 0);
        // Saturation on x2
        for (int i = 0; i < 4; i++) step(1, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        idle(2, 2);

        for (int ph = 0; ph < 8; ph++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            for (int i = 0; i < 300; i++) begin
                v  = ($urandom_range(99) < 80);
                rw = ($urandom_range(99) < 70);
                mr = ($urandom_range(99) < 40);
                fl = ($urandom_range(99) < 8);
                wv = ($urandom_range(99) < 55);
                pend.delete();
                for (int r = 1; r < 8; r++) if (cnt[r] != 0) pend.push_back(r);
                if (pend.size() != 0 && $urandom_range(99) < 96)
                    wr = pend[$urandom_range(pend.size() - 1)];
                else
                    wr = $urandom_range(7);
                step(v, $urandom_range(7), $urandom_range(7), $urandom_range(7),
                     rw, mr, fl, wv, wr, ($urandom_range(199) == 0));
            end
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
